// File: rtl/serial_loader_pkg.sv
// Shared types and limits for the serial word loader.
// Optional parity stage is enabled by defining SERIAL_LOADER_PARITY_EN.
package serial_loader_pkg;

  localparam int STATE_W   = 2;
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

endpackage

// File: rtl/serial_word_shifter.sv
// MSB-first shift register with bit counter; o_word already includes a pending shift
// so the top can capture a completed word on the same edge as the last bit.
module serial_word_shifter
  import serial_loader_pkg::*;
#(
  parameter int width  = 32,
  parameter int cwidth = $clog2(width + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_shift_en,
  input  logic             i_clear,
  input  logic             i_bit,
  output logic [width-1:0] o_word,
  output logic             o_last
);

  logic [width-1:0]  r_word;
  logic [cwidth-1:0] r_count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_word  <= '0;
      r_count <= '0;
    end else begin
      if (i_shift_en) r_word <= {r_word[width-2:0], i_bit};
      if (i_clear) r_count <= '0;
      else if (i_shift_en) r_count <= r_count + 1'b1;
    end
  end

  assign o_word = i_shift_en ? {r_word[width-2:0], i_bit} : r_word;
  assign o_last = i_shift_en && (r_count == cwidth'(width - 1));

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word assembler feeding a width-bit register stage.
// Define SERIAL_LOADER_PARITY_EN to add a trailing even-parity bit per word.
module serial_word_loader
  import serial_loader_pkg::*;
#(
  parameter int width  = 32,
  parameter int cwidth = $clog2(width + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             InBit,
  input  logic             InValid,
  output logic             InReady,
  output logic [width-1:0] Out,
  output logic             OutValid,
  output logic             Busy,
  output logic             Error
);

  if (width < MIN_WIDTH || width > MAX_WIDTH) begin : g_bad_width
    $error("serial_word_loader: width out of range");
  end

  state_t           r_state, w_next;
  logic             w_xfer, w_shift_en, w_last, w_emit_ok;
  logic [width-1:0] w_word;
  logic [width-1:0] r_out;
  logic             r_out_valid, r_busy;
`ifdef SERIAL_LOADER_PARITY_EN
  logic             r_par, r_error, w_emit_err;
`endif

  // InReady depends only on state, Clear and reset, never on InValid.
  assign InReady    = Reset && !Clear && (r_state != ST_EMIT);
  assign w_xfer     = InValid && InReady;
  assign w_shift_en = w_xfer && ((r_state == ST_IDLE) || (r_state == ST_SHIFT));

  serial_word_shifter #(.width(width), .cwidth(cwidth)) u_shifter (
    .Clock      (Clock),
    .Reset      (Reset),
    .i_shift_en (w_shift_en),
    .i_clear    (Clear || (r_state == ST_EMIT)),
    .i_bit      (InBit),
    .o_word     (w_word),
    .o_last     (w_last)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_emit_ok = 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
    w_emit_err = 1'b0;
`endif
    case (r_state)
      ST_IDLE:  if (w_xfer) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) begin
`ifdef SERIAL_LOADER_PARITY_EN
        w_next = ST_PARITY;
`else
        w_next    = ST_EMIT;
        w_emit_ok = 1'b1;
`endif
      end
`ifdef SERIAL_LOADER_PARITY_EN
      ST_PARITY: if (w_xfer) begin
        w_next     = ST_EMIT;
        w_emit_ok  = ~(r_par ^ InBit);
        w_emit_err = r_par ^ InBit;
      end
`else
      ST_PARITY: w_next = ST_IDLE;
`endif
      ST_EMIT:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (Clear) w_next = ST_IDLE;
  end

  // Strobes are registered on the deciding edge so they appear during EMIT.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= w_emit_ok;
      r_busy      <= (w_next != ST_IDLE);
      if (w_emit_ok) r_out <= w_word;
    end
  end

`ifdef SERIAL_LOADER_PARITY_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_par   <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_error <= w_emit_err;
      if (w_shift_en) r_par <= (r_state == ST_IDLE) ? InBit : (r_par ^ InBit);
    end
  end
  assign Error = r_error;
`else
  assign Error = 1'b0;
`endif

  assign Out      = r_out;
  assign OutValid = r_out_valid;
  assign Busy     = r_busy;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader: an 8-bit instance for the single-word
// scenarios and a 32-bit instance for back-to-back throughput.
module tb_serial_word_loader;

`ifdef SERIAL_LOADER_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset;
  logic        Clear8, InBit8, InValid8, InReady8, OutValid8, Busy8, Error8;
  logic [7:0]  Out8;
  logic        Clear32, InBit32, InValid32, InReady32, OutValid32, Busy32, Error32;
  logic [31:0] Out32;

  serial_word_loader #(.width(8)) dut8 (
    .Clock(Clock), .Reset(Reset), .Clear(Clear8), .InBit(InBit8), .InValid(InValid8),
    .InReady(InReady8), .Out(Out8), .OutValid(OutValid8), .Busy(Busy8), .Error(Error8)
  );

  serial_word_loader #(.width(32)) dut32 (
    .Clock(Clock), .Reset(Reset), .Clear(Clear32), .InBit(InBit32), .InValid(InValid32),
    .InReady(InReady32), .Out(Out32), .OutValid(OutValid32), .Busy(Busy32), .Error(Error32)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int strobes8 = 0;
  int errs8 = 0;
  int n32 = 0;
  logic [31:0] got32 [0:15];
  int          at32  [0:15];

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (OutValid8 === 1'b1) strobes8 <= strobes8 + 1;
    if (Error8 === 1'b1) errs8 <= errs8 + 1;
  end

  always @(negedge Clock) begin
    if (OutValid32 === 1'b1 && n32 < 16) begin
      got32[n32] <= Out32;
      at32[n32]  <= cyc;
      n32        <= n32 + 1;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic xfer8(input logic b);
    int guard = 0;
    InValid8 = 1'b1;
    InBit8   = b;
    #0;
    while (InReady8 !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (InReady8 !== 1'b1) begin
      n_total++;
      $display("FAIL xfer8_ready: InReady=%b required 1 within 20 cycles", InReady8);
    end
    tick();
    InValid8 = 1'b0;
  endtask

  task automatic send_data8(input logic [7:0] w, input int stall, output logic busy_ok);
    busy_ok = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      xfer8(w[i]);
      if (i > 0 || EXTRA == 1) begin
        for (int s = 0; s < stall; s++) begin
          if (Busy8 !== 1'b1) busy_ok = 1'b0;
          tick();
        end
      end
    end
  endtask

  task automatic send_word8(input logic [7:0] w, input int stall, output logic busy_ok);
    send_data8(w, stall, busy_ok);
`ifdef SERIAL_LOADER_PARITY_EN
    xfer8(^w);
`endif
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Clear8 = 1'b0; InBit8 = 1'b0; InValid8 = 1'b0;
    Clear32 = 1'b0; InBit32 = 1'b0; InValid32 = 1'b0;
    tick(); tick();
    n_total++; if (InReady8 !== 1'b0) $display("FAIL rst_inready: got %b required 0", InReady8); else n_pass++;
    n_total++; if (Out8 !== 8'h00) $display("FAIL rst_out: got %h required 00", Out8); else n_pass++;
    n_total++; if (OutValid8 !== 1'b0) $display("FAIL rst_outvalid: got %b required 0", OutValid8); else n_pass++;
    n_total++; if (Busy8 !== 1'b0) $display("FAIL rst_busy: got %b required 0", Busy8); else n_pass++;
    n_total++; if (Error8 !== 1'b0) $display("FAIL rst_error: got %b required 0", Error8); else n_pass++;
    Reset = 1'b1;
    tick();
    n_total++; if (InReady8 !== 1'b1) $display("FAIL idle_inready8: got %b required 1", InReady8); else n_pass++;
    n_total++; if (InReady32 !== 1'b1) $display("FAIL idle_inready32: got %b required 1", InReady32); else n_pass++;
  endtask

  task automatic test_basic();
    int s0;
    logic bo;
    s0 = strobes8;
    send_word8(8'hA5, 0, bo);
    n_total++; if (OutValid8 !== 1'b1) $display("FAIL basic_strobe: got %b required 1", OutValid8); else n_pass++;
    n_total++; if (Out8 !== 8'hA5) $display("FAIL basic_out: got %h required a5", Out8); else n_pass++;
    n_total++; if (InReady8 !== 1'b0) $display("FAIL basic_emit_ready: got %b required 0", InReady8); else n_pass++;
    n_total++; if (Error8 !== 1'b0) $display("FAIL basic_error: got %b required 0", Error8); else n_pass++;
    tick();
    n_total++; if (OutValid8 !== 1'b0) $display("FAIL basic_strobe_end: got %b required 0", OutValid8); else n_pass++;
    n_total++; if (InReady8 !== 1'b1) $display("FAIL basic_ready_back: got %b required 1", InReady8); else n_pass++;
    n_total++; if (Busy8 !== 1'b0) $display("FAIL basic_busy_end: got %b required 0", Busy8); else n_pass++;
    n_total++; if (strobes8 - s0 !== 1) $display("FAIL basic_strobe_count: got %0d required 1", strobes8 - s0); else n_pass++;
  endtask

  task automatic test_clear();
    int s0;
    logic bo;
    s0 = strobes8;
    for (int i = 0; i < 4; i++) xfer8(1'b1);
    n_total++; if (Busy8 !== 1'b1) $display("FAIL clear_busy_before: got %b required 1", Busy8); else n_pass++;
    Clear8 = 1'b1; InValid8 = 1'b1; InBit8 = 1'b1;
    #1;
    n_total++; if (InReady8 !== 1'b0) $display("FAIL clear_inready: got %b required 0", InReady8); else n_pass++;
    tick();
    Clear8 = 1'b0; InValid8 = 1'b0;
    #1;
    n_total++; if (Busy8 !== 1'b0) $display("FAIL clear_busy_after: got %b required 0", Busy8); else n_pass++;
    n_total++; if (Out8 !== 8'hA5) $display("FAIL clear_out_kept: got %h required a5", Out8); else n_pass++;
    send_word8(8'h3C, 0, bo);
    n_total++; if (OutValid8 !== 1'b1) $display("FAIL clear_strobe: got %b required 1", OutValid8); else n_pass++;
    n_total++; if (Out8 !== 8'h3C) $display("FAIL clear_out: got %h required 3c", Out8); else n_pass++;
    tick();
    n_total++; if (strobes8 - s0 !== 1) $display("FAIL clear_strobe_count: got %0d required 1", strobes8 - s0); else n_pass++;
  endtask

  task automatic test_stalls();
    int s0;
    logic bo;
    s0 = strobes8;
    send_word8(8'hA5, 3, bo);
    n_total++; if (bo !== 1'b1) $display("FAIL stall_busy: got %b required 1", bo); else n_pass++;
    n_total++; if (OutValid8 !== 1'b1) $display("FAIL stall_strobe: got %b required 1", OutValid8); else n_pass++;
    n_total++; if (Out8 !== 8'hA5) $display("FAIL stall_out: got %h required a5", Out8); else n_pass++;
    tick();
    n_total++; if (strobes8 - s0 !== 1) $display("FAIL stall_strobe_count: got %0d required 1", strobes8 - s0); else n_pass++;
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 3; i++) xfer8(1'b1);
    n_total++; if (Busy8 !== 1'b1) $display("FAIL midrst_busy_before: got %b required 1", Busy8); else n_pass++;
    Reset = 1'b0;
    #1;
    n_total++; if (Out8 !== 8'h00) $display("FAIL midrst_out: got %h required 00", Out8); else n_pass++;
    n_total++; if (Busy8 !== 1'b0) $display("FAIL midrst_busy: got %b required 0", Busy8); else n_pass++;
    n_total++; if (InReady8 !== 1'b0) $display("FAIL midrst_inready: got %b required 0", InReady8); else n_pass++;
    tick();
    Reset = 1'b1;
    #1;
    n_total++; if (InReady8 !== 1'b1) $display("FAIL midrst_ready_after: got %b required 1", InReady8); else n_pass++;
    n_total++; if (OutValid8 !== 1'b0) $display("FAIL midrst_outvalid: got %b required 0", OutValid8); else n_pass++;
    tick();
  endtask

`ifdef SERIAL_LOADER_PARITY_EN
  task automatic test_parity();
    int s0, e0;
    logic bo;
    s0 = strobes8;
    e0 = errs8;
    send_data8(8'hA5, 0, bo);
    xfer8(1'b0);
    n_total++; if (OutValid8 !== 1'b1) $display("FAIL par_ok_strobe: got %b required 1", OutValid8); else n_pass++;
    n_total++; if (Out8 !== 8'hA5) $display("FAIL par_ok_out: got %h required a5", Out8); else n_pass++;
    n_total++; if (Error8 !== 1'b0) $display("FAIL par_ok_error: got %b required 0", Error8); else n_pass++;
    tick();
    send_data8(8'hFF, 0, bo);
    xfer8(1'b1);
    n_total++; if (Error8 !== 1'b1) $display("FAIL par_bad_error: got %b required 1", Error8); else n_pass++;
    n_total++; if (OutValid8 !== 1'b0) $display("FAIL par_bad_strobe: got %b required 0", OutValid8); else n_pass++;
    n_total++; if (Out8 !== 8'hA5) $display("FAIL par_bad_out: got %h required a5", Out8); else n_pass++;
    tick();
    n_total++; if (Error8 !== 1'b0) $display("FAIL par_error_end: got %b required 0", Error8); else n_pass++;
    n_total++; if (InReady8 !== 1'b1) $display("FAIL par_ready_back: got %b required 1", InReady8); else n_pass++;
    n_total++; if (errs8 - e0 !== 1) $display("FAIL par_error_count: got %0d required 1", errs8 - e0); else n_pass++;
    n_total++; if (strobes8 - s0 !== 1) $display("FAIL par_strobe_count: got %0d required 1", strobes8 - s0); else n_pass++;
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] exp [0:9];
    int bpw, total, k, guard, base, wi, bi;
    logic rdy;
    bpw = 32 + EXTRA;
    total = 10 * bpw;
    base = n32;
    for (int i = 0; i < 10; i++) exp[i] = $urandom;
    k = 0;
    guard = 0;
    while (k < total && guard < 1000) begin
      wi = k / bpw;
      bi = k % bpw;
      InBit32   = (bi < 32) ? exp[wi][31-bi] : ^exp[wi];
      InValid32 = 1'b1;
      #0;
      rdy = InReady32;
      tick();
      guard++;
      if (rdy === 1'b1) k++;
    end
    InValid32 = 1'b0;
    if (k != total) begin
      n_total++;
      $display("FAIL b2b_timeout: sent %0d bits required %0d", k, total);
    end
    repeat (4) tick();
    n_total++; if (n32 - base !== 10) $display("FAIL b2b_strobe_count: got %0d required 10", n32 - base); else n_pass++;
    for (int i = 0; i < 10 && base + i < 16; i++) begin
      n_total++;
      if (got32[base+i] !== exp[i]) $display("FAIL b2b_word%0d: got %h required %h", i, got32[base+i], exp[i]);
      else n_pass++;
    end
    for (int i = 1; i < 10 && base + i < 16; i++) begin
      n_total++;
      if (at32[base+i] - at32[base+i-1] !== 33 + EXTRA)
        $display("FAIL b2b_spacing%0d: got %0d required %0d", i, at32[base+i] - at32[base+i-1], 33 + EXTRA);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear();
    test_stalls();
    test_reset_midword();
`ifdef SERIAL_LOADER_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_word_loader.md
# serial_word_loader

Serial-to-parallel word assembler that sits directly upstream of the general-purpose `width`-bit register stage. It accepts a bit stream under a valid/ready handshake, assembles `width` bits MSB-first, and presents the finished word with a one-cycle `OutValid` strobe. That strobe is wired straight to the downstream register's `Enable`, and `Out` is wired to its `In`. An optional trailing even-parity bit lets corrupted words be dropped before they reach the register.

## Interface
Parameters:
- `width`, 32, word width in bits; must match the downstream register; legal range 2..64.
- `cwidth`, `$clog2(width+1)`, bit-counter width (derived; not overridden).

Ports:
- `Clock`  in  1  rising-edge clock, single clock domain.
- `Reset`  in  1  asynchronous, active-low reset.
- `Clear`  in  1  synchronous abort; discards any partial word.
- `InBit`  in  1  serial data bit.
- `InValid`  in  1  `InBit` is valid this cycle.
- `InReady`  out  1  loader accepts a bit this cycle; a transfer occurs when `InValid && InReady`.
- `Out`  out  `width`  last completed word; stable between strobes.
- `OutValid`  out  1  one-cycle strobe: `Out` holds a new word.
- `Busy`  out  1  a word is partially assembled (state ≠ IDLE).
- `Error`  out  1  one-cycle strobe: parity failure, word dropped. Tied 0 when parity is compiled out.

## Operation
- States: IDLE, SHIFT, PARITY (only with `SERIAL_LOADER_PARITY_EN`), EMIT.
- IDLE:
  - `InReady=1`.
  - The first transfer loads the bit into the shift register LSB, sets count=1, and moves to SHIFT.
- SHIFT:
  - `InReady=1`.
  - Each transfer shifts left and inserts `InBit` at the LSB, so the first-received bit ends up at `Out[width-1]`; count increments.
  - When the transfer bringing count to `width` occurs:
    - with parity: go to PARITY;
    - without parity: go to EMIT.
- PARITY:
  - `InReady=1`.
  - On transfer, compute the XOR of all `width` data bits and the parity bit.
  - XOR = 0: EMIT with ok. XOR = 1: EMIT with fail.
- EMIT:
  - `InReady=0` for exactly one cycle.
  - If ok: `Out` ← shift register and `OutValid=1`.
  - If fail: `Out` is unchanged and `Error=1`.
  - Next state: IDLE; count clears.
- Clear:
  - In any state, forces IDLE next cycle and clears count.
  - `Out` is retained.
  - `InReady=0` while `Clear=1`, so no bit is accepted that cycle.
- Clear during EMIT: the strobe for that cycle still fires (EMIT is already committed); the next state is IDLE.
- `InValid` low in any state: hold state, no shift.
- Reset values: state IDLE, count 0, shift register 0, `Out` 0, `OutValid` 0, `Error` 0, `Busy` 0, `InReady` 0 while `Reset` is asserted and 1 afterwards (IDLE).
- Reset mid-word: the partial word is lost; `Out` returns to 0.

## Timing
- `OutValid`, `Error`, `Busy` and `Out` are registered outputs. `InReady` is decoded from state and `Clear` only, with no combinational path from `InValid`.
- Last data bit transferred at cycle T (no parity): `OutValid=1` and `Out` valid in cycle T+1; `InReady=1` again at T+2.
- With parity, parity bit transferred at cycle P: strobe in cycle P+1; `InReady=1` at P+2.
- Peak throughput: one word per `width`+1 cycles, or `width`+2 with parity.
- Downstream register captures `Out` on the edge ending cycle T+1 and shows it one cycle later.

## Configuration
- `SERIAL_LOADER_PARITY_EN` defined:
  - PARITY state exists; one extra bit per word.
  - Even parity over data+parity.
  - On failure: `Error` pulses, `OutValid` stays low, `Out` is not updated.
- Undefined:
  - No PARITY state; SHIFT goes directly to EMIT.
  - `Error` is constant 0.
  - Port list is unchanged.

## Structure
- Shared package `serial_loader_pkg`:
  - state enum (IDLE, SHIFT, PARITY, EMIT);
  - state encoding width constant;
  - `MIN_WIDTH=2` / `MAX_WIDTH=64` constants for the parameter check.
- One sub-module, `serial_word_shifter`:
  - shift register plus bit counter;
  - ports: shift enable, clear, `InBit`, word out, `Last` flag (count == `width`-1 with a shift pending).
- FSM, parity accumulator and output register live in the top level.

## Test plan
- Reset and idle: assert `Reset` low mid-word, release. Required: `Out=0`, `OutValid=0`, `Busy=0`, `InReady=1`.
- Basic word, `width=8`, no parity: bits 1,0,1,0,0,1,0,1 back-to-back. Required: `OutValid` for one cycle at T+1, `Out=8'hA5`, `InReady` low exactly that cycle.
- Stalls: same word with `InValid` low for 3 cycles between each bit. Required: `Out=8'hA5`, single strobe, `Busy` high throughout.
- Clear mid-word: 4 bits, then `Clear`, then a full 8'h3C. Required: one strobe, `Out=8'h3C`, and no bit accepted during the `Clear` cycle.
- Parity (`SERIAL_LOADER_PARITY_EN`): 8'hA5 + parity 0 → `OutValid`, `Out=8'hA5`. Then 8'hFF + parity 1 → `Error` pulse, no `OutValid`, `Out` remains 8'hA5.
- Back-to-back words, `width=32`: 10 random words with `InValid` held high. Required: 10 strobes at 33-cycle spacing, every word matching the scoreboard.
